// File: rtl/layer_ser_pkg.sv
// Shared types for the layer serializer: shifter state and index-width helper.
package layer_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Index width for an NN-element vector; never narrower than one bit.
  function automatic int idx_w(input int nn);
    return (nn > 1) ? $clog2(nn) : 1;
  endfunction

endpackage

// File: rtl/layer_serializer_if.sv
// Parallel-in / serial-out bus of the layer serializer.
interface layer_serializer_if #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
);
  logic [NN-1:0]           i_valid;
  logic [NN*dataWidth-1:0] i_data;
  logic                    o_valid;
  logic [dataWidth-1:0]    o_data;
  logic                    o_last;
  logic                    busy;
  logic                    overrun;

  // master: upstream layer / stimulus side; slave: the serializer
  modport master (
    output i_valid, i_data,
    input  o_valid, o_data, o_last, busy, overrun
  );
  modport slave (
    input  i_valid, i_data,
    output o_valid, o_data, o_last, busy, overrun
  );
endinterface

// File: rtl/layer_ser_collect.sv
// Masked per-element collect stage with optional shadow vector.
// Optional feature: LAYER_SER_SHADOW_EN adds one shadow vector register.
module layer_ser_collect #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NN-1:0]                   i_valid,
  input  logic [NN-1:0][dataWidth-1:0]    i_data,
  input  logic                            i_vec_take,
  output logic                            o_vec_avail,
  output logic [NN-1:0][dataWidth-1:0]    o_vec_data,
  output logic                            o_drop
);

  logic [NN-1:0][dataWidth-1:0] r_col_data;
  logic [NN-1:0]                r_col_mask;
  logic [NN-1:0][dataWidth-1:0] w_merged;
  logic [NN-1:0]                w_wr;
  logic [NN-1:0]                w_mask_nx;
  logic                         w_col_pend;
  logic                         w_col_full;
  logic                         w_col_clr;

  // A complete vector parked in collect blocks every new strobe.
  assign w_col_pend = &r_col_mask;
  assign w_wr       = w_col_pend ? '0 : i_valid;
  assign w_mask_nx  = r_col_mask | w_wr;
  assign w_col_full = &w_mask_nx;
  assign o_drop     = w_col_pend & (|i_valid);

  always_comb begin
    w_merged = r_col_data;
    for (int k = 0; k < NN; k++)
      if (w_wr[k]) w_merged[k] = i_data[k];
  end

`ifdef LAYER_SER_SHADOW_EN
  logic [NN-1:0][dataWidth-1:0] r_shd_data;
  logic                         r_shd_vld;
  logic                         w_take_shd;
  logic                         w_take_col;
  logic                         w_move;

  // Shadow holds the older vector, so it is always consumed first.
  assign w_take_shd  = i_vec_take & r_shd_vld;
  assign w_take_col  = i_vec_take & ~r_shd_vld;
  assign w_move      = w_col_full & ~w_take_col & (~r_shd_vld | w_take_shd);
  assign w_col_clr   = w_take_col | w_move;
  assign o_vec_avail = r_shd_vld | w_col_full;
  assign o_vec_data  = r_shd_vld ? r_shd_data : w_merged;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shd_vld  <= 1'b0;
      r_shd_data <= '0;
    end else begin
      r_shd_vld <= w_move | (r_shd_vld & ~w_take_shd);
      if (w_move) r_shd_data <= w_merged;
    end
  end
`else
  assign w_col_clr   = i_vec_take;
  assign o_vec_avail = w_col_full;
  assign o_vec_data  = w_merged;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_mask <= '0;
      r_col_data <= '0;
    end else begin
      r_col_mask <= w_col_clr ? '0 : w_mask_nx;
      r_col_data <= w_merged;
    end
  end

endmodule

// File: rtl/layer_serializer.sv
// Parallel-to-serial bridge between neural layers: collects NN results, streams them out.
// Optional feature: LAYER_SER_SHADOW_EN (shadow vector in layer_ser_collect).
module layer_serializer
  import layer_ser_pkg::*;
#(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic              clk,
  input  logic              rst,
  layer_serializer_if.slave bus
);

  localparam int                 IDX_W    = idx_w(NN);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NN - 1);

  logic [NN-1:0][dataWidth-1:0] w_in_data;
  logic [NN-1:0][dataWidth-1:0] w_vec_data;
  logic                         w_vec_avail;
  logic                         w_take;
  logic                         w_free;
  logic                         w_drop;
  logic [IDX_W-1:0]             w_idx_nx;

  ser_state_t                   r_state;
  logic [IDX_W-1:0]             r_idx;
  logic [NN-1:0][dataWidth-1:0] r_sh_data;
  logic                         r_o_valid;
  logic [dataWidth-1:0]         r_o_data;
  logic                         r_o_last;
  logic                         r_overrun;

  assign w_in_data = bus.i_data;

  layer_ser_collect #(
    .NN        (NN),
    .dataWidth (dataWidth)
  ) u_collect (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (bus.i_valid),
    .i_data      (w_in_data),
    .i_vec_take  (w_take),
    .o_vec_avail (w_vec_avail),
    .o_vec_data  (w_vec_data),
    .o_drop      (w_drop)
  );

  // Shifter accepts a new vector when idle or while emitting its last element.
  assign w_free   = (r_state == IDLE) | (r_idx == LAST_IDX);
  assign w_take   = w_free & w_vec_avail;
  assign w_idx_nx = r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_sh_data <= '0;
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_last  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun | w_drop;
      if (w_take) begin
        r_state   <= SHIFT;
        r_idx     <= '0;
        r_sh_data <= w_vec_data;
        r_o_valid <= 1'b1;
        r_o_data  <= w_vec_data[0];
        r_o_last  <= 1'b0;
      end else if (r_state == SHIFT && !w_free) begin
        r_idx     <= w_idx_nx;
        r_o_data  <= r_sh_data[w_idx_nx];
        r_o_last  <= (w_idx_nx == LAST_IDX);
      end else begin
        r_state   <= IDLE;
        r_idx     <= '0;
        r_o_valid <= 1'b0;
        r_o_data  <= '0;
        r_o_last  <= 1'b0;
      end
    end
  end

  assign bus.o_valid = r_o_valid;
  assign bus.o_data  = r_o_data;
  assign bus.o_last  = r_o_last;
  assign bus.busy    = (r_state == SHIFT);
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: directed steps plus random strobes against a queue model.
module tb_layer_serializer;
  localparam int NN = 4;
  localparam int DW = 16;
`ifdef LAYER_SER_SHADOW_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef logic [NN-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer_serializer_if #(.NN(NN), .dataWidth(DW)) bus ();

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: partial vector, queue of complete vectors waiting (collect + shadow),
  // and the vector currently streaming with the index on the output.
  vec_t          m_col;
  logic [NN-1:0] m_mask;
  vec_t          wq[$];
  vec_t          m_cur;
  int            m_k;
  logic          m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col  = '0;
    m_mask = '0;
    wq.delete();
    m_k    = -1;
    m_ovr  = 1'b0;
  endtask

  task automatic model_edge(input logic [NN-1:0] v, input vec_t d);
    if (wq.size() == CAP) begin
      if (|v) m_ovr = 1'b1;
    end else begin
      for (int k = 0; k < NN; k++)
        if (v[k]) begin m_col[k] = d[k]; m_mask[k] = 1'b1; end
      if (&m_mask) begin wq.push_back(m_col); m_mask = '0; end
    end
    if (m_k < 0 || m_k == NN - 1) begin
      if (wq.size() > 0) begin m_cur = wq.pop_front(); m_k = 0; end
      else m_k = -1;
    end else m_k++;
  endtask

  task automatic check_outs();
    chk("o_valid", 32'(bus.o_valid), 32'(m_k >= 0));
    if (m_k >= 0) chk("o_data", 32'(bus.o_data), 32'(m_cur[m_k]));
    chk("o_last", 32'(bus.o_last), 32'(m_k == NN - 1));
    chk("busy", 32'(bus.busy), 32'(m_k >= 0));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  task automatic step(input logic [NN-1:0] v, input vec_t d);
    bus.i_valid = v;
    bus.i_data  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    bus.i_valid = '0;
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0);
  endtask

  function automatic vec_t mkv(input logic [15:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    bus.i_valid = '0;
    bus.i_data  = '0;
    #1;
    chk("rst o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst o_data", 32'(bus.o_data), 32'd0);
    chk("rst o_last", 32'(bus.o_last), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst overrun", 32'(bus.overrun), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int   run;
    vec_t rv;
    logic [NN-1:0] rb;
    bus.i_valid = '0;
    bus.i_data  = '0;

    // reset and quiet idle
    do_reset();
    idle(10);

    // single vector
    step(4'b1111, mkv(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    chk("single e0", 32'(bus.o_data), 32'h0001);
    idle(3);
    chk("single e3", 32'(bus.o_data), 32'h0004);
    chk("single last", 32'(bus.o_last), 32'd1);
    idle(3);

    // staggered strobes with element 0 rewritten before completion
    step(4'b0100, mkv(16'h0, 16'h0, 16'h0C02, 16'h0));
    step(4'b0001, mkv(16'h0C00, 16'h0, 16'h0, 16'h0));
    step(4'b0001, mkv(16'h00AA, 16'h0, 16'h0, 16'h0));
    step(4'b1000, mkv(16'h0, 16'h0, 16'h0, 16'h0C03));
    chk("stagger wait", 32'(bus.o_valid), 32'd0);
    step(4'b0010, mkv(16'h0, 16'h0C01, 16'h0, 16'h0));
    chk("stagger e0", 32'(bus.o_data), 32'h00AA);
    idle(5);

    // back-to-back: B completes while A shifts
    run = 0;
    step(4'b1111, mkv(16'hA000, 16'hA001, 16'hA002, 16'hA003));
    run += int'(bus.o_valid);
    step('0, '0);
    run += int'(bus.o_valid);
    step(4'b1111, mkv(16'hB000, 16'hB001, 16'hB002, 16'hB003));
    run += int'(bus.o_valid);
    for (int i = 0; i < 5; i++) begin
      step('0, '0);
      run += int'(bus.o_valid);
    end
    chk("b2b run", 32'(run), 32'd8);
    chk("b2b overrun", 32'(bus.overrun), 32'd0);
    idle(2);

    // overrun: A shifting, B pending, C bit 0, then rest of C and a full D
    step(4'b1111, mkv(16'h1A00, 16'h1A01, 16'h1A02, 16'h1A03));
    step(4'b1111, mkv(16'h1B00, 16'h1B01, 16'h1B02, 16'h1B03));
    step(4'b0001, mkv(16'h1C00, 16'h0, 16'h0, 16'h0));
    chk("ovr C0", 32'(bus.overrun), 32'(CAP == 1));
    step(4'b1110, mkv(16'h0, 16'h1C01, 16'h1C02, 16'h1C03));
    step(4'b1111, mkv(16'h1D00, 16'h1D01, 16'h1D02, 16'h1D03));
    chk("ovr D", 32'(bus.overrun), 32'd1);
    idle(14);

    // random strobes, several rounds so the sticky overrun gets re-armed
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 100; c++) begin
        for (int k = 0; k < NN; k++) rv[k] = DW'($urandom);
        if ($urandom_range(0, 5) == 0) rb = '1;
        else for (int k = 0; k < NN; k++) rb[k] = ($urandom_range(0, 3) == 0);
        step(rb, rv);
      end
      idle(10);
    end

    // reset in the middle of a stream aborts it at once
    do_reset();
    step(4'b1111, mkv(16'h5550, 16'h5551, 16'h5552, 16'h5553));
    step('0, '0);
    do_reset();
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
